// File: rtl/adder_acc.sv
// Accumulates ACCLEN unsigned samples per window and presents the window result with a valid/ready handshake.
// Define ADDER_ACC_AVG_EN to output the truncated mean instead of the full sum.
module adder_acc #(
    parameter int BITWIDTH = 8,
    parameter int ACCLEN   = 16
) (
    input  logic                              iClk,
    input  logic                              iRst,
    input  logic                              iClr,
    input  logic                              iValid,
    input  logic [BITWIDTH:0]                 iData,
    output logic                              oReady,
    output logic                              oValid,
`ifdef ADDER_ACC_AVG_EN
    output logic [BITWIDTH:0]                 oData,
`else
    output logic [BITWIDTH+$clog2(ACCLEN):0]  oData,
`endif
    input  logic                              iReady
);

    localparam int CNTW = $clog2(ACCLEN);
    localparam int SUMW = BITWIDTH + 1 + CNTW;
`ifdef ADDER_ACC_AVG_EN
    localparam int OUTW = BITWIDTH + 1;
`else
    localparam int OUTW = SUMW;
`endif

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SUMW-1:0]   sum_q, sum_d, sum_acc;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [OUTW-1:0]   data_q, data_d;
    logic              last_sample;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_ACC;
            sum_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // SUMW is wide enough for ACCLEN full-scale samples, so this add never wraps.
    assign sum_acc     = sum_q + SUMW'(iData);
    assign last_sample = (cnt_q == CNTW'(ACCLEN - 1));

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (iClr) begin
            state_d = ST_ACC;
            sum_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            data_d  = '0;
        end else if (state_q == ST_ACC) begin
            if (iValid) begin
                sum_d = sum_acc;
                cnt_d = cnt_q + CNTW'(1);
                if (last_sample) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    cnt_d   = '0;
`ifdef ADDER_ACC_AVG_EN
                    data_d  = sum_acc[SUMW-1:CNTW];
`else
                    data_d  = sum_acc;
`endif
                end
            end
        end else if (iReady) begin
            // Drain edge: the sample presented on this edge is not taken.
            state_d = ST_ACC;
            valid_d = 1'b0;
            sum_d   = '0;
            cnt_d   = '0;
        end
    end

    assign oReady = (state_q == ST_ACC);
    assign oValid = valid_q;
    assign oData  = data_q;

endmodule

// File: tb/tb_adder_acc.sv
// Randomized and directed bench for adder_acc (BITWIDTH=8, ACCLEN=4) against a sample-list reference model.
module tb_adder_acc;

    localparam int BW = 8;
    localparam int AL = 4;
`ifdef ADDER_ACC_AVG_EN
    localparam int OW = BW + 1;
`else
    localparam int OW = BW + 1 + 2;
`endif

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iClr;
    logic          iValid;
    logic [BW:0]   iData;
    logic          oReady;
    logic          oValid;
    logic [OW-1:0] oData;
    logic          iReady;

    adder_acc #(.BITWIDTH(BW), .ACCLEN(AL)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iClr   (iClr),
        .iValid (iValid),
        .iData  (iData),
        .oReady (oReady),
        .oValid (oValid),
        .oData  (oData),
        .iReady (iReady)
    );

    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;

    // Reference model: samples of the open window, plus the pending result.
    bit m_done  = 1'b0;
    bit m_valid = 1'b0;
    int m_res   = 0;
    int m_win[$];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int sel(input int full, input int avg);
`ifdef ADDER_ACC_AVG_EN
        return avg;
`else
        return full;
`endif
    endfunction

    function automatic int win_result();
        int s = 0;
        foreach (m_win[i]) s += m_win[i];
        return sel(s, s / AL);
    endfunction

    task automatic model_reset();
        m_win.delete();
        m_done  = 1'b0;
        m_valid = 1'b0;
        m_res   = 0;
    endtask

    task automatic model_edge();
        if (iClr) begin
            model_reset();
        end else if (!m_done) begin
            if (iValid) begin
                m_win.push_back(int'(iData));
                if (m_win.size() == AL) begin
                    m_res   = win_result();
                    m_valid = 1'b1;
                    m_done  = 1'b1;
                    m_win.delete();
                end
            end
        end else if (iReady) begin
            m_valid = 1'b0;
            m_done  = 1'b0;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".ready"}, int'(oReady), int'(!m_done));
        chk({tag, ".valid"}, int'(oValid), int'(m_valid));
        chk({tag, ".data"},  int'(oData),  m_res);
    endtask

    task automatic step(input bit clr, input bit v, input int d, input bit rdy, input string tag);
        iClr   = clr;
        iValid = v;
        iData  = d[BW:0];
        iReady = rdy;
        @(posedge iClk);
        model_edge();
        #1;
        $display("txn %s clr=%0b v=%0b d=%0d rdy=%0b -> ready=%0b valid=%0b data=%0d",
                 tag, clr, v, d, rdy, oReady, oValid, oData);
        check_outs(tag);
    endtask

    // Called just after an edge; asserts and releases reset well before the next edge.
    task automatic async_reset(input string tag);
        #2 iRst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".rst_valid"}, int'(oValid), 0);
        chk({tag, ".rst_data"},  int'(oData),  0);
        chk({tag, ".rst_ready"}, int'(oReady), 1);
        #2 iRst = 1'b0;
    endtask

    initial begin
        iRst = 1'b1; iClr = 1'b0; iValid = 1'b0; iData = '0; iReady = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        check_outs("reset");
        #2 iRst = 1'b0;

        // Basic window
        step(0, 1, 10, 1, "basic");
        step(0, 1, 20, 1, "basic");
        step(0, 1, 30, 1, "basic");
        step(0, 1, 40, 1, "basic");
        chk("basic.result", int'(oData), sel(100, 25));
        chk("basic.valid1", int'(oValid), 1);
        step(0, 0, 0, 1, "basic_drain");

        // Gaps and backpressure
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, k, 0, "gap");
            if (k < 4) begin
                step(0, 0, 0, 0, "gap_idle");
                step(0, 0, 0, 0, "gap_idle");
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, int'($urandom_range(0, 511)), 0, "hold");
            chk("hold.result", int'(oData), sel(10, 2));
            chk("hold.ready0", int'(oReady), 0);
        end
        step(0, 1, 99, 1, "gap_drain");
        chk("gap_drain.valid0", int'(oValid), 0);

        // Max value, then a small window
        for (int i = 0; i < 4; i++) step(0, 1, 511, 0, "max");
        chk("max.result", int'(oData), sel(2044, 511));
        step(0, 0, 0, 1, "max_drain");
        step(0, 1, 0, 0, "small");
        step(0, 1, 0, 0, "small");
        step(0, 1, 0, 0, "small");
        step(0, 1, 4, 0, "small");
        chk("small.result", int'(oData), sel(4, 1));
        step(0, 0, 0, 1, "small_drain");

        // Clear discards a partial window
        step(0, 1, 100, 0, "clr_part");
        step(0, 1, 100, 0, "clr_part");
        step(1, 0, 0, 0, "clr");
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, "clr_win");
        chk("clr_win.result", int'(oData), sel(4, 1));
        step(0, 0, 0, 1, "clr_drain");

        // Clear priority over acceptance and over drain
        step(0, 1, 7, 0, "prio_part");
        step(1, 1, 50, 0, "prio_acc");
        for (int i = 0; i < 4; i++) step(0, 1, 2, 0, "prio_win");
        chk("prio_win.result", int'(oData), sel(8, 2));
        step(1, 1, 60, 1, "prio_done");
        chk("prio_done.valid0", int'(oValid), 0);
        chk("prio_done.data0",  int'(oData), 0);
        for (int i = 0; i < 4; i++) step(0, 1, 3, 0, "prio_next");
        chk("prio_next.result", int'(oData), sel(12, 3));
        step(0, 0, 0, 1, "prio_drain");

        // Asynchronous reset in DONE and mid-window
        for (int i = 0; i < 4; i++) step(0, 1, 9, 0, "rst_win");
        async_reset("rst_done");
        for (int i = 0; i < 3; i++) step(0, 1, 5, 0, "rst_part");
        async_reset("rst_mid");
        for (int i = 0; i < 4; i++) step(0, 1, 5, 0, "rst_new");
        chk("rst_new.result", int'(oData), sel(20, 5));
        step(0, 0, 0, 1, "rst_drain");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 19) == 0),
                 bit'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 511)),
                 bit'($urandom_range(0, 2) != 0),
                 "rand");
            if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
